load_unit: RTL and testbench
============================

# load_unit

Load unit for the JAMIA core, directly upstream of the write-back mux selection stage. Accepts one load request per transaction from the pipeline and issues a word-aligned request to data memory with a req/ack handshake. Extracts and sign/zero-extends the addressed byte, halfword or word and presents it on `lu_output_out`, which feeds the write-back mux LU input. Stalls the pipeline for the duration of the transaction and reports bus errors and timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of request cycles without ack before a timeout fault; legal range 1..1023.

- `clk_in`  in  1  core clock; all state on rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `load_valid_in`  in  1  single-cycle load request pulse from the pipeline.
- `load_addr_in`  in  32  byte address; sampled on accept.
- `load_size_in`  in  2  00 byte, 01 half, 10 word, 11 treated as word; sampled on accept.
- `load_unsigned_in`  in  1  1 = zero-extend, 0 = sign-extend; sampled on accept.
- `dmem_req_out`  out  1  memory request, registered.
- `dmem_addr_out`  out  32  `{addr[31:2],2'b00}` of the accepted load; 0 when idle.
- `dmem_ack_in`  in  1  memory data valid.
- `dmem_err_in`  in  1  memory access error.
- `dmem_rdata_in`  in  32  memory read data, valid with ack.
- `lu_output_out`  out  32  extended load result to the WB mux.
- `lu_done_out`  out  1  one-cycle completion pulse.
- `stall_out`  out  1  pipeline hold.
- `fault_out`  out  1  high with `lu_done_out` when the load failed.
- `misaligned_out`  out  1  high with `lu_done_out` on a misaligned load (see Configuration).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `load_valid_in`=1 → capture addr/size/unsigned, clear timeout counter, → WAIT (or → RESP on misaligned, macro on). `dmem_ack_in`/`dmem_err_in` ignored.
- WAIT: `dmem_req_out`=1. Sampled `dmem_err_in`=1 → fault, result 0, → RESP. Else `dmem_ack_in`=1 → capture extracted data, → RESP. Else counter+1; counter reaching `TIMEOUT_CYCLES` → fault, result 0, → RESP.
- Priority in one cycle: err > ack > timeout.
- RESP: `lu_done_out`=1 one cycle; `fault_out`/`misaligned_out` valid this cycle only; → IDLE.
- `load_valid_in` in WAIT or RESP is ignored (no queueing).
- Extraction, off = addr[1:0]: byte = `rdata[8*off+7:8*off]`; half = `rdata[31:16]` if addr[1] else `rdata[15:0]`; word = `rdata`. Extend bit 7/15 unless unsigned.
- `lu_output_out` holds its last value until the next RESP entry.
- Reset: state IDLE, counter 0, all outputs 0. Reset mid-WAIT drops `dmem_req_out` immediately; no done pulse; a late ack is ignored.

## Timing
- Accept at edge T; `dmem_req_out` high from T to the edge where ack/err/timeout is sampled.
- Ack sampled at edge A → `lu_output_out` valid and `lu_done_out` high in cycle after A. Minimum load latency: 2 cycles accept→done.
- `stall_out` = (IDLE & `load_valid_in`) | WAIT; combinational; low in RESP.
- Timeout: done pulse `TIMEOUT_CYCLES`+1 cycles after accept.

## Configuration
- `LU_MISALIGN_TRAP_EN` defined: half with addr[0]=1 or word with addr[1:0]≠0 issues no memory request; IDLE → RESP directly, `fault_out`=`misaligned_out`=1, result 0, done 1 cycle after accept.
- Undefined: no check; half uses addr[1] only, word ignores addr[1:0]; `misaligned_out` tied 0.

## Test plan
- LB addr 0x103, signed, ack first cycle, rdata 0x80AA_5511 → `dmem_addr_out`=0x100, done 2 cycles after accept, `lu_output_out`=0xFFFF_FF80.
- LHU addr 0x2002, ack after 3 WAIT cycles, rdata 0x8001_7FFF → `lu_output_out`=0x0000_8001, `stall_out` high 4 cycles, done 5 cycles after accept.
- LW, `dmem_ack_in` and `dmem_err_in` both high → `fault_out`=1, `lu_output_out`=0.
- TIMEOUT_CYCLES=4, no ack → done and `fault_out` 5 cycles after accept, `dmem_req_out` low afterward.
- LW addr 0x101: macro on → no `dmem_req_out`, `misaligned_out`=`fault_out`=1 next cycle; macro off → request to 0x100, full word returned.
- `rst_n_in` low during WAIT → `dmem_req_out` 0 immediately, all outputs 0, subsequent ack produces no done pulse.

Source files
------------

// File: rtl/load_unit.sv
// Load unit: word-aligned dmem req/ack transaction, byte/half/word extraction, bus-error and timeout faults.
// Optional LU_MISALIGN_TRAP_EN: misaligned half/word loads trap without a memory request.
module load_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        load_valid_in,
    input  logic [31:0] load_addr_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    output logic        dmem_req_out,
    output logic [31:0] dmem_addr_out,
    input  logic        dmem_ack_in,
    input  logic        dmem_err_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] lu_output_out,
    output logic        lu_done_out,
    output logic        stall_out,
    output logic        fault_out,
    output logic        misaligned_out
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [9:0]  cnt;
    logic [9:0]  cnt_nxt;
    logic        fault_q;
    logic [31:0] result;
    logic        req_q;
    logic [31:0] daddr_q;
    logic        accept;
    logic        mis_in;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign accept  = (state == S_IDLE) && load_valid_in;
    assign cnt_nxt = cnt + 10'd1;

`ifdef LU_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis_in = ((load_size_in == 2'b01) && load_addr_in[0]) ||
                    (load_size_in[1] && (load_addr_in[1:0] != 2'b00));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   mis_q <= 1'b0;
        else if (accept) mis_q <= mis_in;
    end

    assign misaligned_out = lu_done_out & mis_q;
`else
    assign mis_in         = 1'b0;
    assign misaligned_out = 1'b0;
`endif

    // Extraction works on the captured offset/size, so rdata only needs to be valid with ack.
    always_comb begin
        shifted = dmem_rdata_in >> {off_q, 3'b000};
        ext     = dmem_rdata_in;
        case (size_q)
            2'b00:   ext = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
            2'b01:   ext = off_q[1] ? {{16{dmem_rdata_in[31] & ~uns_q}}, dmem_rdata_in[31:16]}
                                    : {{16{dmem_rdata_in[15] & ~uns_q}}, dmem_rdata_in[15:0]};
            default: ext = dmem_rdata_in;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= S_IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            cnt     <= 10'd0;
            fault_q <= 1'b0;
            result  <= 32'd0;
            req_q   <= 1'b0;
            daddr_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_valid_in) begin
                        off_q   <= load_addr_in[1:0];
                        size_q  <= load_size_in;
                        uns_q   <= load_unsigned_in;
                        cnt     <= 10'd0;
                        fault_q <= 1'b0;
                        if (mis_in) begin
                            fault_q <= 1'b1;
                            result  <= 32'd0;
                            state   <= S_RESP;
                        end else begin
                            req_q   <= 1'b1;
                            daddr_q <= {load_addr_in[31:2], 2'b00};
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // err beats ack beats timeout when they coincide
                    if (dmem_err_in || dmem_ack_in || (cnt_nxt == TO_LIM)) begin
                        req_q   <= 1'b0;
                        daddr_q <= 32'd0;
                        state   <= S_RESP;
                        if (!dmem_err_in && dmem_ack_in) begin
                            result  <= ext;
                        end else begin
                            fault_q <= 1'b1;
                            result  <= 32'd0;
                        end
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req_out  = req_q;
    assign dmem_addr_out = daddr_q;
    assign lu_output_out = result;
    assign lu_done_out   = (state == S_RESP);
    assign fault_out     = lu_done_out & fault_q;
    assign stall_out     = accept | (state == S_WAIT);

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit (TIMEOUT_CYCLES=4); follows LU_MISALIGN_TRAP_EN if defined.
module tb_load_unit;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        load_valid_in = 1'b0;
    logic [31:0] load_addr_in = 32'd0;
    logic [1:0]  load_size_in = 2'b00;
    logic        load_unsigned_in = 1'b0;
    logic        dmem_req_out;
    logic [31:0] dmem_addr_out;
    logic        dmem_ack_in = 1'b0;
    logic        dmem_err_in = 1'b0;
    logic [31:0] dmem_rdata_in = 32'd0;
    logic [31:0] lu_output_out;
    logic        lu_done_out;
    logic        stall_out;
    logic        fault_out;
    logic        misaligned_out;

    int checks = 0;
    int errors = 0;

    load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .load_valid_in(load_valid_in), .load_addr_in(load_addr_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .dmem_req_out(dmem_req_out), .dmem_addr_out(dmem_addr_out),
        .dmem_ack_in(dmem_ack_in), .dmem_err_in(dmem_err_in), .dmem_rdata_in(dmem_rdata_in),
        .lu_output_out(lu_output_out), .lu_done_out(lu_done_out), .stall_out(stall_out),
        .fault_out(fault_out), .misaligned_out(misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Presents a load in the current cycle, accepts it on the next edge, leaves the bench in cycle 1.
    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        load_valid_in = 1'b1; load_addr_in = a; load_size_in = sz; load_unsigned_in = uns;
        step();
        load_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({dmem_req_out, lu_done_out, stall_out, fault_out, misaligned_out} !== 5'b0 ||
            dmem_addr_out !== 32'd0 || lu_output_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h out=%h done=%b stall=%b flt=%b mis=%b want all 0",
                     dmem_req_out, dmem_addr_out, lu_output_out, lu_done_out, stall_out, fault_out, misaligned_out);
        end
        step();
        rst_n_in = 1'b1;
        step();
    endtask

    task automatic test_lb_signed();
        load_valid_in = 1'b1; load_addr_in = 32'h103; load_size_in = 2'b00; load_unsigned_in = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin errors++; $display("FAIL lb_stall_accept: got %b want 1", stall_out); end
        step();
        load_valid_in = 1'b0;
        checks++;
        if (dmem_req_out !== 1'b1 || dmem_addr_out !== 32'h100) begin
            errors++; $display("FAIL lb_req: req=%b addr=%h want 1/00000100", dmem_req_out, dmem_addr_out);
        end
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'h80AA_5511;
        step();
        dmem_ack_in = 1'b0;
        checks++;
        if (lu_done_out !== 1'b1 || lu_output_out !== 32'hFFFF_FF80 || fault_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL lb_result: done=%b out=%h flt=%b stall=%b want 1/ffffff80/0/0",
                     lu_done_out, lu_output_out, fault_out, stall_out);
        end
        checks++;
        if (dmem_req_out !== 1'b0 || dmem_addr_out !== 32'd0) begin
            errors++; $display("FAIL lb_req_drop: req=%b addr=%h want 0/0", dmem_req_out, dmem_addr_out);
        end
        step();
        checks++;
        if (lu_done_out !== 1'b0 || lu_output_out !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_hold: done=%b out=%h want 0/ffffff80", lu_done_out, lu_output_out);
        end
    endtask

    // Ack lands on the cycle the timeout counter would expire; ack must win.
    task automatic test_lhu_wait();
        int stalls = 0;
        int cyc = 1;
        issue(32'h2002, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (stall_out === 1'b1) stalls++;
            load_valid_in = (i == 1);   // ignored while busy
            load_addr_in  = 32'hABC0;
            step();
            cyc++;
        end
        load_valid_in = 1'b0;
        checks++;
        if (dmem_addr_out !== 32'h2000) begin
            errors++; $display("FAIL lhu_addr_kept: got %h want 00002000", dmem_addr_out);
        end
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'h8001_7FFF;
        if (stall_out === 1'b1) stalls++;
        step();
        cyc++;
        dmem_ack_in = 1'b0;
        checks++;
        if (lu_done_out !== 1'b1 || cyc != 5) begin
            errors++; $display("FAIL lhu_latency: done=%b at cycle %0d want 1 at 5", lu_done_out, cyc);
        end
        checks++;
        if (lu_output_out !== 32'h0000_8001 || fault_out !== 1'b0) begin
            errors++; $display("FAIL lhu_result: out=%h flt=%b want 00008001/0", lu_output_out, fault_out);
        end
        checks++;
        if (stalls != 4 || stall_out !== 1'b0) begin
            errors++; $display("FAIL lhu_stall: %0d cycles, now %b; want 4, 0", stalls, stall_out);
        end
        step();
    endtask

    task automatic test_extract();
        logic [31:0] a  [4] = '{32'h0, 32'h5, 32'h6, 32'h3};
        logic [1:0]  sz [4] = '{2'b01, 2'b00, 2'b01, 2'b11};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] rd [4] = '{32'h1234_8001, 32'h0000_9A00, 32'h7FFE_0000, 32'hCAFE_F00D};
        logic [31:0] ex [4] = '{32'hFFFF_8001, 32'h0000_009A, 32'h0000_7FFE, 32'hCAFE_F00D};
        for (int i = 0; i < 4; i++) begin
`ifdef LU_MISALIGN_TRAP_EN
            if (i == 3) a[i] = 32'h0;
`endif
            issue(a[i], sz[i], un[i]);
            dmem_ack_in = 1'b1; dmem_rdata_in = rd[i];
            step();
            dmem_ack_in = 1'b0;
            checks++;
            if (lu_done_out !== 1'b1 || lu_output_out !== ex[i]) begin
                errors++; $display("FAIL extract_%0d: done=%b out=%h want 1/%h", i, lu_done_out, lu_output_out, ex[i]);
            end
            step();
        end
    endtask

    task automatic test_err_ack();
        issue(32'h200, 2'b10, 1'b0);
        dmem_ack_in = 1'b1; dmem_err_in = 1'b1; dmem_rdata_in = 32'h1234_5678;
        step();
        dmem_ack_in = 1'b0; dmem_err_in = 1'b0;
        checks++;
        if (lu_done_out !== 1'b1 || fault_out !== 1'b1 || lu_output_out !== 32'd0 || misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL err_ack: done=%b flt=%b out=%h mis=%b want 1/1/0/0",
                     lu_done_out, fault_out, lu_output_out, misaligned_out);
        end
        step();
        checks++;
        if (fault_out !== 1'b0) begin errors++; $display("FAIL err_fault_pulse: got %b want 0", fault_out); end
    endtask

    task automatic test_timeout();
        int cyc = 1;
        issue(32'h300, 2'b10, 1'b0);
        while (lu_done_out !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (lu_done_out !== 1'b1 || cyc != 5) begin
            errors++; $display("FAIL timeout_latency: done=%b at cycle %0d want 1 at 5", lu_done_out, cyc);
        end
        checks++;
        if (fault_out !== 1'b1 || lu_output_out !== 32'd0 || dmem_req_out !== 1'b0) begin
            errors++; $display("FAIL timeout_fault: flt=%b out=%h req=%b want 1/0/0", fault_out, lu_output_out, dmem_req_out);
        end
        step();
        checks++;
        if (dmem_req_out !== 1'b0 || lu_done_out !== 1'b0) begin
            errors++; $display("FAIL timeout_after: req=%b done=%b want 0/0", dmem_req_out, lu_done_out);
        end
    endtask

    task automatic test_misalign();
        issue(32'h101, 2'b10, 1'b0);
`ifdef LU_MISALIGN_TRAP_EN
        checks++;
        if (dmem_req_out !== 1'b0 || lu_done_out !== 1'b1 || fault_out !== 1'b1 ||
            misaligned_out !== 1'b1 || lu_output_out !== 32'd0) begin
            errors++;
            $display("FAIL misalign_trap: req=%b done=%b flt=%b mis=%b out=%h want 0/1/1/1/0",
                     dmem_req_out, lu_done_out, fault_out, misaligned_out, lu_output_out);
        end
        step();
`else
        checks++;
        if (dmem_req_out !== 1'b1 || dmem_addr_out !== 32'h100) begin
            errors++; $display("FAIL misalign_req: req=%b addr=%h want 1/00000100", dmem_req_out, dmem_addr_out);
        end
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'hDEAD_BEEF;
        step();
        dmem_ack_in = 1'b0;
        checks++;
        if (lu_done_out !== 1'b1 || lu_output_out !== 32'hDEAD_BEEF || fault_out !== 1'b0 || misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL misalign_word: done=%b out=%h flt=%b mis=%b want 1/deadbeef/0/0",
                     lu_done_out, lu_output_out, fault_out, misaligned_out);
        end
        step();
`endif
    endtask

    task automatic test_reset_mid_wait();
        int dones = 0;
        issue(32'h400, 2'b10, 1'b0);
        step();
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (dmem_req_out !== 1'b0 || dmem_addr_out !== 32'd0 || lu_output_out !== 32'd0 ||
            stall_out !== 1'b0 || lu_done_out !== 1'b0 || fault_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: req=%b addr=%h out=%h stall=%b done=%b flt=%b want all 0",
                     dmem_req_out, dmem_addr_out, lu_output_out, stall_out, lu_done_out, fault_out);
        end
        step();
        rst_n_in = 1'b1;
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            if (lu_done_out === 1'b1 || dmem_req_out === 1'b1) dones++;
        end
        dmem_ack_in = 1'b0;
        checks++;
        if (dones != 0) begin errors++; $display("FAIL late_ack: %0d done/req cycles want 0", dones); end
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_lhu_wait();
        test_extract();
        test_err_ack();
        test_timeout();
        test_misalign();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
